// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: capture FSM states, record flag
// bit positions and a flag-vector packing helper.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT_PEND,
    ST_DRAIN,
    ST_DONE
  } trace_state_t;

  localparam int unsigned FLG_W   = 4;
  localparam int unsigned FLG_REG = 0;
  localparam int unsigned FLG_LD  = 1;
  localparam int unsigned FLG_ST  = 2;
  localparam int unsigned FLG_HLT = 3;

  // Consumer-side view of out_flags; field order matches the FLG_* indices.
  typedef struct packed {
    logic hlt;
    logic st;
    logic ld;
    logic rg;
  } trace_flags_t;

  function automatic logic [FLG_W-1:0] pack_flags(input logic rg, input logic ld,
                                                  input logic st, input logic hl);
    logic [FLG_W-1:0] f;
    f          = '0;
    f[FLG_REG] = rg;
    f[FLG_LD]  = ld;
    f[FLG_ST]  = st;
    f[FLG_HLT] = hl;
    return f;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered write and combinational head read.
// Pointers carry one extra wrap bit so full/empty need no separate flag.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// On-chip commit trace: packs writeback/memory events into records, buffers
// them in trace_fifo and streams them out. Per-record stamps: TRACE_TIMESTAMP_EN.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_wa,
  input  logic [DATA_W-1:0] reg_wd,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              hlt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_flags,
  output logic [REG_AW-1:0] out_reg_wa,
  output logic [DATA_W-1:0] out_reg_wd,
  output logic [DATA_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [CNT_W-1:0]  out_cycle,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  stamp;
`endif
    logic [FLG_W-1:0]  flags;
    logic [REG_AW-1:0] reg_wa;
    logic [DATA_W-1:0] reg_wd;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

  trace_state_t state;
  trace_state_t state_nxt;

  rec_t             run_rec;
  rec_t             halt_rec;
  rec_t             push_rec;
  rec_t             head_rec;
  logic [REC_W-1:0] fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  logic ev;
  logic inst_ev;
  logic push_ok;
  logic arm_go;

`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] halt_cyc;
`endif

  assign ev       = reg_we | mem_re | mem_we | hlt;
  assign inst_ev  = reg_we | mem_we | hlt;
  assign fifo_pop = !fifo_empty && out_ready;
  assign push_ok  = !fifo_full || fifo_pop;
  assign arm_go   = arm && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    run_rec       = '0;
    run_rec.flags = pack_flags(reg_we, mem_re, mem_we, hlt);
    if (reg_we) begin
      run_rec.reg_wa = reg_wa;
      run_rec.reg_wd = reg_wd;
    end
    if (mem_re || mem_we) run_rec.mem_addr = mem_addr;
    // Store data wins when a cycle both loads and stores.
    if (mem_we)      run_rec.mem_data = mem_wdata;
    else if (mem_re) run_rec.mem_data = mem_rdata;
`ifdef TRACE_TIMESTAMP_EN
    run_rec.stamp = cyc_cnt;
`endif
  end

  always_comb begin
    halt_rec       = '0;
    halt_rec.flags = pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef TRACE_TIMESTAMP_EN
    halt_rec.stamp = halt_cyc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (arm) state_nxt = ST_RUN;
      ST_RUN:           if (hlt) state_nxt = push_ok ? ST_DRAIN : ST_HALT_PEND;
      ST_HALT_PEND:     if (push_ok) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (fifo_count == '0) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
    push_rec   = run_rec;
    done       = 1'b0;
    unique case (state)
      ST_IDLE:      fifo_clear = arm;
      ST_RUN:       fifo_push  = ev;
      ST_HALT_PEND: begin
        fifo_push = 1'b1;
        push_rec  = halt_rec;
      end
      ST_DRAIN:     ;
      ST_DONE: begin
        done       = 1'b1;
        fifo_clear = arm;
      end
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      halt_cyc <= '0;
`endif
    end else if (arm_go) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (state == ST_RUN) begin
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (inst_ev && (inst_cnt != '1)) inst_cnt <= inst_cnt + CNT_W'(1);
      if (ev && !hlt && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
`ifdef TRACE_TIMESTAMP_EN
      if (hlt) halt_cyc <= cyc_cnt;
`endif
    end else if (state == ST_HALT_PEND) begin
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fifo_clear),
    .push  (fifo_push),
    .din   (push_rec),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields are masked while empty so stale RAM contents never leak out.
  assign head_rec     = fifo_dout;
  assign out_valid    = !fifo_empty;
  assign out_flags    = out_valid ? head_rec.flags    : '0;
  assign out_reg_wa   = out_valid ? head_rec.reg_wa   : '0;
  assign out_reg_wd   = out_valid ? head_rec.reg_wd   : '0;
  assign out_mem_addr = out_valid ? head_rec.mem_addr : '0;
  assign out_mem_data = out_valid ? head_rec.mem_data : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign out_cycle    = out_valid ? head_rec.stamp    : '0;
`else
  assign out_cycle    = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: table-driven record vectors plus
// hand-written overflow, halt-pending, full-with-pop and mid-run reset sequences.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, reg_we, mem_re, mem_we, hlt, out_ready;
  logic [3:0]  reg_wa;
  logic [15:0] reg_wd, mem_addr, mem_wdata, mem_rdata;
  logic        out_valid, done, overflow;
  logic [3:0]  out_flags;
  logic [3:0]  out_reg_wa;
  logic [15:0] out_reg_wd, out_mem_addr, out_mem_data;
  logic [31:0] out_cycle, cyc_cnt, inst_cnt, drop_cnt;

  commit_trace_buffer #(
    .DATA_W (16),
    .REG_AW (4),
    .DEPTH  (DEPTH),
    .CNT_W  (32)
  ) dut (
    .clk (clk), .rst_n (rst_n), .arm (arm),
    .reg_we (reg_we), .reg_wa (reg_wa), .reg_wd (reg_wd),
    .mem_re (mem_re), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .hlt (hlt),
    .out_valid (out_valid), .out_ready (out_ready), .out_flags (out_flags),
    .out_reg_wa (out_reg_wa), .out_reg_wd (out_reg_wd),
    .out_mem_addr (out_mem_addr), .out_mem_data (out_mem_data),
    .out_cycle (out_cycle), .done (done), .overflow (overflow),
    .cyc_cnt (cyc_cnt), .inst_cnt (inst_cnt), .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  flags;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    bit rwe; bit [3:0] wa; bit [15:0] wd; bit mre; bit mwe;
    bit [15:0] addr; bit [15:0] wdata; bit [15:0] rdata;
    bit [3:0] xflags; bit [3:0] xwa; bit [15:0] xwd; bit [15:0] xaddr; bit [15:0] xdata;
  } vec_t;

  typedef enum int {M_IDLE, M_RUN, M_HP, M_DRAIN, M_DONE} mstate_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  exp_t    q[$];
  mstate_t m_st  = M_IDLE;
  int      m_occ = 0;
  int      m_cyc = 0, m_inst = 0, m_drop = 0, m_hcyc = 0;
  bit      m_ovf = 0;
  vec_t    vecs[8];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] stamp(input int c);
`ifdef TRACE_TIMESTAMP_EN
    return c;
`else
    return 32'h0;
`endif
  endfunction

  function automatic exp_t build_exp(input bit rwe, input bit [3:0] wa, input bit [15:0] wd,
                                     input bit mre, input bit mwe, input bit [15:0] addr,
                                     input bit [15:0] wdata, input bit [15:0] rdata, input bit h);
    exp_t e;
    e       = '0;
    e.flags = {h, mwe, mre, rwe};
    if (rwe) begin e.wa = wa; e.wd = wd; end
    if (mre || mwe) e.addr = addr;
    e.data  = mwe ? wdata : (mre ? rdata : 16'h0);
    return e;
  endfunction

  // One clock: drive inputs, advance the scoreboard model, check the head
  // record on the handshake edge, then check statistics after the edge.
  task automatic step(input bit a, input bit rwe, input bit [3:0] wa, input bit [15:0] wd,
                      input bit mre, input bit mwe, input bit [15:0] addr,
                      input bit [15:0] wdata, input bit [15:0] rdata, input bit h,
                      input bit rdy, input bit use_ex, input exp_t ex);
    exp_t e;
    bit   ev, pop, ok;
    arm = a; reg_we = rwe; reg_wa = wa; reg_wd = wd; mem_re = mre; mem_we = mwe;
    mem_addr = addr; mem_wdata = wdata; mem_rdata = rdata; hlt = h; out_ready = rdy;
    ev  = rwe | mre | mwe | h;
    pop = (m_occ > 0) && rdy;
    ok  = (m_occ < DEPTH) || pop;
    case (m_st)
      M_IDLE, M_DONE: if (a) begin
        m_st = M_RUN; m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0;
      end
      M_RUN: begin
        if (ev) begin
          if (ok) begin
            e     = use_ex ? ex : build_exp(rwe, wa, wd, mre, mwe, addr, wdata, rdata, h);
            e.cyc = stamp(m_cyc);
            q.push_back(e);
            m_occ++;
          end else if (!h) begin
            m_drop++;
            m_ovf = 1;
          end
        end
        if (rwe || mwe || h) m_inst++;
        if (h) begin
          m_hcyc = m_cyc;
          m_st   = ok ? M_DRAIN : M_HP;
        end
        m_cyc++;
      end
      M_HP: begin
        if (ok) begin
          e       = '0;
          e.flags = 4'b1000;
          e.cyc   = stamp(m_hcyc);
          q.push_back(e);
          m_occ++;
          m_st = M_DRAIN;
        end
        m_cyc++;
      end
      M_DRAIN: if (m_occ == 0) m_st = M_DONE;
      default: ;
    endcase
    if (pop) m_occ--;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_record", {out_flags, out_reg_wa, out_reg_wd, out_mem_addr, out_mem_data, out_cycle}, '0);
      end else begin
        e = q.pop_front();
        chk("record", {out_flags, out_reg_wa, out_reg_wd, out_mem_addr, out_mem_data, out_cycle}, e);
      end
    end
    @(posedge clk);
    #1;
    chk("cyc_cnt",   cyc_cnt,   m_cyc);
    chk("inst_cnt",  inst_cnt,  m_inst);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("overflow",  overflow,  m_ovf);
    chk("done",      done,      m_st == M_DONE);
    chk("out_valid", out_valid, m_occ > 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, '0);
  endtask

  task automatic do_arm(input bit rdy);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, '0);
  endtask

  task automatic store(input bit [15:0] addr, input bit [15:0] data, input bit rdy);
    step(0, 0, 0, 0, 0, 1, addr, data, 16'hDEAD, 0, rdy, 0, '0);
  endtask

  task automatic halt(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rdy, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (m_st == M_DONE) break;
      idle(1);
    end
    chk("done_after_drain", done, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{0, 4'h7, 16'h1111, 0, 0, 16'h2222, 16'h3333, 16'h4444, 4'b0000, 4'h0, 0, 0, 0};
    vecs[1] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'h0, 0, 0, 0};
    vecs[2] = '{1, 4'h3, 16'h00A5, 0, 0, 0, 0, 0, 4'b0001, 4'h3, 16'h00A5, 0, 0};
    vecs[3] = '{1, 4'h1, 16'h0010, 1, 0, 16'h0040, 16'h1234, 16'hBEEF, 4'b0011, 4'h1, 16'h0010, 16'h0040, 16'hBEEF};
    vecs[4] = '{0, 4'h9, 16'h9999, 0, 1, 16'h0080, 16'h5555, 16'h6666, 4'b0100, 4'h0, 0, 16'h0080, 16'h5555};
    vecs[5] = '{0, 4'h0, 0, 1, 0, 16'h00C0, 16'h1212, 16'h7777, 4'b0010, 4'h0, 0, 16'h00C0, 16'h7777};
    vecs[6] = '{0, 4'h0, 0, 1, 1, 16'h0100, 16'hAAAA, 16'hBBBB, 4'b0110, 4'h0, 0, 16'h0100, 16'hAAAA};
    vecs[7] = '{1, 4'hF, 16'hFFFF, 0, 1, 16'hFFFE, 16'h0001, 16'h0000, 4'b0101, 4'hF, 16'hFFFF, 16'hFFFE, 16'h0001};

    rst_n = 0; arm = 0; reg_we = 0; reg_wa = 0; reg_wd = 0; mem_re = 0; mem_we = 0;
    mem_addr = 0; mem_wdata = 0; mem_rdata = 0; hlt = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_flags, out_reg_wa, out_reg_wd, out_mem_addr, out_mem_data, out_cycle}, '0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_counters", {cyc_cnt, inst_cnt, drop_cnt}, '0);
    rst_n = 1;

    // Events before arming are ignored.
    step(0, 1, 4'h2, 16'h0022, 0, 1, 16'h0004, 16'h0044, 0, 0, 1, 0, '0);
    idle(1);

    // Table vectors, consumer always ready.
    do_arm(1);
    foreach (vecs[i]) begin
      step(0, vecs[i].rwe, vecs[i].wa, vecs[i].wd, vecs[i].mre, vecs[i].mwe, vecs[i].addr,
           vecs[i].wdata, vecs[i].rdata, 0, 1, 1,
           {vecs[i].xflags, vecs[i].xwa, vecs[i].xwd, vecs[i].xaddr, vecs[i].xdata, 32'h0});
      if (i == 2) chk("inst_after_r3", inst_cnt, 1);
      if (i == 3) chk("inst_after_reg_load", inst_cnt, 2);
    end
    halt(1);
    drain();

    // Overflow: 20 stores into a 16-deep FIFO with no consumer, then a halt
    // that must wait for space.
    do_arm(0);
    for (int i = 0; i < 20; i++) store(16'(i + 16'h0200), 16'(i * 3 + 1), 0);
    chk("ovf_drop_cnt", drop_cnt, 4);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_inst_cnt", inst_cnt, 20);
    halt(0);
    step(0, 1, 4'h5, 16'h0505, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    store(16'h0300, 16'h0303, 0);
    idle(0);
    chk("hp_done_low", done, 0);
    chk("hp_drop_cnt", drop_cnt, 4);
    drain();

    // Full FIFO with a pop in the same cycle accepts the new record.
    do_arm(0);
    for (int i = 0; i < 16; i++) store(16'(16'h0400 + i), 16'(16'h1000 + i), 0);
    chk("full_drop_cnt", drop_cnt, 0);
    step(1, 1, 4'h6, 16'h0666, 0, 0, 0, 0, 0, 0, 1, 0, '0);
    chk("full_pop_drop_cnt", drop_cnt, 0);
    chk("full_pop_overflow", overflow, 0);
    halt(1);
    drain();

    // Asynchronous reset mid-run discards everything.
    do_arm(0);
    for (int i = 0; i < 5; i++) store(16'(16'h0500 + i), 16'(16'h2000 + i), 0);
    rst_n = 0;
    #2;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_counters", {cyc_cnt, inst_cnt, drop_cnt}, '0);
    chk("mid_rst_done", done, 0);
    q.delete();
    m_st = M_IDLE; m_occ = 0; m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 1, 4'h7, 16'h0777, 1, 0, 16'h0010, 0, 16'h0011, 0, 1, 0, '0);
    store(16'h0600, 16'h0606, 1);
    chk("post_rst_inst_cnt", inst_cnt, 0);
    do_arm(1);
    step(0, 1, 4'h8, 16'h0888, 0, 0, 0, 0, 0, 0, 1, 0, '0);
    halt(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
